pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RISC-V pipeline.
//
// Mirrors the register tags of the instructions in EX, MEM and WB. From them it
// derives per-stage advance enables, IF/ID flush, ID/EX bubble, PC increment and
// the EX operand-forwarding selects.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded fields of the instruction currently in ID
//   ex_branch_taken          EX-stage branch/jump resolved taken
//   hold_req                 external freeze of the whole pipeline
//   *_advance                pipeline register write enables
//   pc_inc                   PC increment enable
//   if_id_flush              load NOP into IF/ID
//   id_ex_bubble             load NOP into ID/EX
//   fwd_a_sel, fwd_b_sel     EX operand source: 00 regfile, 01 MEM, 10 WB
//   stall_cycles             saturating count of hazard-stall cycles
//
// Configuration macro: PIPELINE_CTRL_FORWARDING_EN
//   defined   -> MEM/WB forwarding active, only load-use and WB matches stall
//   undefined -> selects tied to 00, any EX/MEM/WB match stalls

module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_rd_wr,
  input  logic                      id_is_load,
  input  logic                      ex_branch_taken,
  input  logic                      hold_req,
  output logic                      if_id_advance,
  output logic                      id_ex_advance,
  output logic                      ex_mem_advance,
  output logic                      mem_wb_advance,
  output logic                      pc_inc,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic  v;
    logic  wr;
    logic  ld;
    addr_t rd;
  } slot_t;

  // Source fields are only tracked for the EX slot, where forwarding needs them.
  typedef struct packed {
    addr_t rs1;
    addr_t rs2;
    logic  rs1_used;
    logic  rs2_used;
  } src_t;

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  src_t  src_q, src_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic id_dep_ex, id_dep_mem, id_dep_wb;
  logic haz;

  // x0 never matches: it is hardwired to zero and never a real dependency.
  function automatic logic src_match(input logic used, input addr_t rs, input slot_t s);
    return used && (rs != '0) && s.v && s.wr && (s.rd == rs);
  endfunction

  always_comb begin
    id_dep_ex  = src_match(id_rs1_used, id_rs1_addr, ex_q) |
                 src_match(id_rs2_used, id_rs2_addr, ex_q);
    id_dep_mem = src_match(id_rs1_used, id_rs1_addr, mem_q) |
                 src_match(id_rs2_used, id_rs2_addr, mem_q);
    id_dep_wb  = src_match(id_rs1_used, id_rs1_addr, wb_q) |
                 src_match(id_rs2_used, id_rs2_addr, wb_q);
`ifdef PIPELINE_CTRL_FORWARDING_EN
    // WB still stalls: the regfile has no write-through bypass into ID.
    haz = id_valid & ((id_dep_ex & ex_q.ld) | id_dep_wb);
`else
    haz = id_valid & (id_dep_ex | id_dep_mem | id_dep_wb);
`endif
  end

`ifdef PIPELINE_CTRL_FORWARDING_EN
  // A load result is not available from MEM yet, so MEM forwarding skips loads.
  function automatic logic [1:0] fwd_sel(input logic used, input addr_t rs);
    if (!ex_q.v) return 2'b00;
    if (src_match(used, rs, mem_q) && !mem_q.ld) return 2'b01;
    if (src_match(used, rs, wb_q)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!rst) begin
      fwd_a_sel = fwd_sel(src_q.rs1_used, src_q.rs1);
      fwd_b_sel = fwd_sel(src_q.rs2_used, src_q.rs2);
    end
  end

  logic unused_sig;
  assign unused_sig = ^{wb_q.ld, id_dep_mem};
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  logic unused_sig;
  assign unused_sig = ^{wb_q.ld, ex_q.ld, mem_q.ld, src_q};
`endif

  always_comb begin
    if_id_advance  = 1'b0;
    id_ex_advance  = 1'b0;
    ex_mem_advance = 1'b0;
    mem_wb_advance = 1'b0;
    pc_inc         = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_d           = ex_q;
    src_d          = src_q;
    mem_d          = mem_q;
    wb_d           = wb_q;
    cnt_d          = cnt_q;
    if (rst || hold_req) begin
      // Reset clears state in the register block; hold freezes everything.
    end else if (ex_branch_taken) begin
      if_id_advance  = 1'b1;
      id_ex_advance  = 1'b1;
      ex_mem_advance = 1'b1;
      mem_wb_advance = 1'b1;
      pc_inc         = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      ex_d           = '0;
      src_d          = '0;
      mem_d          = ex_q;
      wb_d           = mem_q;
    end else if (haz) begin
      id_ex_advance  = 1'b1;
      ex_mem_advance = 1'b1;
      mem_wb_advance = 1'b1;
      id_ex_bubble   = 1'b1;
      ex_d           = '0;
      src_d          = '0;
      mem_d          = ex_q;
      wb_d           = mem_q;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      if_id_advance  = 1'b1;
      id_ex_advance  = 1'b1;
      ex_mem_advance = 1'b1;
      mem_wb_advance = 1'b1;
      pc_inc         = 1'b1;
      ex_d           = '{v: id_valid, wr: id_rd_wr, ld: id_is_load, rd: id_rd_addr};
      src_d          = '{rs1: id_rs1_addr, rs2: id_rs2_addr,
                         rs1_used: id_rs1_used, rs2_used: id_rs2_used};
      mem_d          = ex_q;
      wb_d           = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      src_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      src_q <= src_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 32;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam int D1_STALLS = 0;
  localparam int D2_STALLS = 0;
`else
  localparam int D1_STALLS = 3;
  localparam int D2_STALLS = 2;
`endif
  localparam int D3_STALLS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_wr = 1'b0, id_is_load = 1'b0;
  logic ex_branch_taken = 1'b0, hold_req = 1'b0;
  logic if_id_advance, id_ex_advance, ex_mem_advance, mem_wb_advance;
  logic pc_inc, if_id_flush, id_ex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .hold_req(hold_req),
    .if_id_advance(if_id_advance), .id_ex_advance(id_ex_advance),
    .ex_mem_advance(ex_mem_advance), .mem_wb_advance(mem_wb_advance),
    .pc_inc(pc_inc), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic v; logic wr; logic ld; logic u1; logic u2;
    logic [AW-1:0] rd; logic [AW-1:0] rs1; logic [AW-1:0] rs2;
  } instr_t;

  typedef struct packed {
    logic [3:0] adv; logic pc; logic fl; logic bb;
    logic [1:0] fa; logic [1:0] fb; logic [CW-1:0] cnt;
  } exp_t;

  exp_t   sb[$];
  instr_t pipe[$];   // in-flight instructions, oldest last: EX, MEM, WB
  instr_t prog[$];
  instr_t cur;
  logic   need_new = 1'b1;
  logic [CW-1:0] m_cnt = '0;
  int n_cmp = 0, n_err = 0;
  int hold_n = 0, br_n = 0, rst_n_cyc = 0;
  int hold_pct = 0, br_pct = 0, rst_pct = 0;
  bit rnd_instr = 1'b0;

  function automatic instr_t mk(logic [AW-1:0] rd, logic wr, logic ld,
                                logic [AW-1:0] rs1, logic u1, logic [AW-1:0] rs2, logic u2);
    instr_t r;
    r = '{v: 1'b1, wr: wr, ld: ld, u1: u1, u2: u2, rd: rd, rs1: rs1, rs2: rs2};
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.v   = ($urandom_range(0, 9) < 8);
    r.wr  = $urandom_range(0, 1) != 0;
    r.ld  = $urandom_range(0, 3) == 0;
    r.u1  = $urandom_range(0, 3) != 0;
    r.u2  = $urandom_range(0, 1) != 0;
    r.rd  = AW'($urandom_range(0, 3));
    r.rs1 = AW'($urandom_range(0, 3));
    r.rs2 = AW'($urandom_range(0, 3));
    return r;
  endfunction

  // True when instruction p will write the register the consumer reads.
  function automatic bit writes(instr_t p, logic used, logic [AW-1:0] rs);
    return used && (rs != 0) && p.v && p.wr && (p.rd == rs);
  endfunction

  function automatic logic [1:0] fsel(logic used, logic [AW-1:0] rs);
`ifdef PIPELINE_CTRL_FORWARDING_EN
    if (!pipe[0].v) return 2'b00;
    if (writes(pipe[1], used, rs) && !pipe[1].ld) return 2'b01;
    if (writes(pipe[2], used, rs)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic clear_pipe();
    pipe.delete();
    repeat (3) pipe.push_back('0);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    bit hold, br, haz, dep_ex, dep_mem, dep_wb;
    @(posedge clk);
    #1;
    if (need_new) begin
      if (prog.size() > 0) cur = prog.pop_front();
      else if (rnd_instr) cur = rand_instr();
      else cur = '0;
      need_new = 1'b0;
    end
    rst  = (rst_n_cyc > 0) || ($urandom_range(0, 99) < rst_pct);
    hold = (hold_n > 0) || ($urandom_range(0, 99) < hold_pct);
    br   = (br_n > 0) || ($urandom_range(0, 99) < br_pct);
    if (rst_n_cyc > 0) rst_n_cyc--;
    if (hold_n > 0) hold_n--;
    if (br_n > 0) br_n--;
    id_valid = cur.v; id_rd_addr = cur.rd; id_rd_wr = cur.wr; id_is_load = cur.ld;
    id_rs1_addr = cur.rs1; id_rs1_used = cur.u1;
    id_rs2_addr = cur.rs2; id_rs2_used = cur.u2;
    hold_req = hold; ex_branch_taken = br;

    e = '0;
    e.cnt = m_cnt;
    if (rst) begin
      clear_pipe();
      m_cnt = '0;
    end else begin
      e.fa = fsel(pipe[0].u1, pipe[0].rs1);
      e.fb = fsel(pipe[0].u2, pipe[0].rs2);
      dep_ex  = writes(pipe[0], cur.u1, cur.rs1) || writes(pipe[0], cur.u2, cur.rs2);
      dep_mem = writes(pipe[1], cur.u1, cur.rs1) || writes(pipe[1], cur.u2, cur.rs2);
      dep_wb  = writes(pipe[2], cur.u1, cur.rs1) || writes(pipe[2], cur.u2, cur.rs2);
`ifdef PIPELINE_CTRL_FORWARDING_EN
      haz = cur.v && ((dep_ex && pipe[0].ld) || dep_wb);
      if (dep_mem) haz = haz;
`else
      haz = cur.v && (dep_ex || dep_mem || dep_wb);
`endif
      if (hold) begin
        // nothing moves
      end else if (br) begin
        e.adv = 4'b1111; e.pc = 1'b1; e.fl = 1'b1; e.bb = 1'b1;
        pipe.push_front('0);
        void'(pipe.pop_back());
      end else if (haz) begin
        e.adv = 4'b0111; e.bb = 1'b1;
        pipe.push_front('0);
        void'(pipe.pop_back());
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end else begin
        e.adv = 4'b1111; e.pc = 1'b1;
        pipe.push_front(cur);
        void'(pipe.pop_back());
      end
    end
    need_new = e.adv[3];
    sb.push_back(e);
  endtask

  task automatic run_prog();
    int guard = 0;
    while ((prog.size() > 0 || !need_new) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("prog_timeout", 32'(guard), 32'd0);
    repeat (4) step();
  endtask

  task automatic delta_test(string name, int exp_stalls);
    logic [CW-1:0] c0;
    c0 = stall_cycles;
    run_prog();
    check(name, stall_cycles - c0, 32'(exp_stalls));
  endtask

  // Monitor: every cycle the DUT presents a full set of control outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("advances", {28'd0, if_id_advance, id_ex_advance, ex_mem_advance, mem_wb_advance},
              {28'd0, e.adv});
        check("pc_inc", {31'd0, pc_inc}, {31'd0, e.pc});
        check("if_id_flush", {31'd0, if_id_flush}, {31'd0, e.fl});
        check("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e.bb});
        check("fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, e.fa});
        check("fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, e.fb});
        check("stall_cycles", stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    clear_pipe();
    // Reset held two cycles with a valid instruction waiting in ID.
    prog.push_back(mk(5'd8, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
    rst_n_cyc = 2;
    step(); step();
    run_prog();

    // RAW at distance 1, 2, 3.
    prog.push_back(mk(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    prog.push_back(mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1));
    delta_test("raw_dist1", D1_STALLS);
    prog.push_back(mk(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    prog.push_back(mk(5'd9, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
    prog.push_back(mk(5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1));
    delta_test("raw_dist2", D2_STALLS);
    prog.push_back(mk(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    prog.push_back(mk(5'd9, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
    prog.push_back(mk(5'd10, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1));
    prog.push_back(mk(5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1));
    delta_test("raw_dist3", D3_STALLS);

    // Forwarding pair and load-use with an x0 source.
    prog.push_back(mk(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    prog.push_back(mk(5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1));
    run_prog();
    prog.push_back(mk(5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0));
    prog.push_back(mk(5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b1));
    run_prog();

    // Branch arriving while the dependent instruction sits in ID.
    prog.push_back(mk(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    prog.push_back(mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1));
    step();
    br_n = 1;
    run_prog();

    // Hold for four cycles in the middle of a load-use stall.
    prog.push_back(mk(5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0));
    prog.push_back(mk(5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1));
    step(); step();
    hold_n = 4;
    run_prog();

    // Randomized traffic with branches, holds and occasional resets.
    rnd_instr = 1'b1; br_pct = 10; hold_pct = 10; rst_pct = 2;
    repeat (1500) step();

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
